// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: default line/clock rates and receiver FSM state encodings.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_rx_pkg;

    localparam int DEF_CLK_HZ       = 12_000_000;
    localparam int DEF_BIT_RATE     = 9_600;
    localparam int DEF_PAYLOAD_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_RECOVER = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and enable in, framed payload and status pulses out.
// Latency: n/a (wiring only).
// Backpressure: none; result pulses are fire-and-forget, consumers must sample them.
interface uart_rx_if
    import uart_rx_pkg::*;
#(
    parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS
);
    logic                    uart_rxd;
    logic                    uart_rx_en;
    logic                    uart_rx_valid;
    logic [PAYLOAD_BITS-1:0] uart_rx_data;
    logic                    uart_rx_frame_err;
    logic                    uart_rx_break;
    logic                    uart_rx_busy;

    modport master (
        input  uart_rxd, uart_rx_en,
        output uart_rx_valid, uart_rx_data, uart_rx_frame_err, uart_rx_break, uart_rx_busy
    );

    modport slave (
        output uart_rxd, uart_rx_en,
        input  uart_rx_valid, uart_rx_data, uart_rx_frame_err, uart_rx_break, uart_rx_busy
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset to a chosen level.
// Latency: 2 clock cycles.
// Backpressure: none.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic resetn,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: N data bits, 1 stop bit, mid-bit sampling, frame error / break detect.
// Latency: valid rises HALF_BIT + (PAYLOAD_BITS+1)*CYCLES_PER_BIT + 1 cycles after leaving IDLE.
// Backpressure: none; uart_rx_en only gates acceptance of new start edges.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int BIT_RATE     = DEF_BIT_RATE,
    parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS
) (
    input  logic      clock,
    input  logic      resetn,
    uart_rx_if.master rx
);
    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
    localparam int IDX_W          = $clog2(PAYLOAD_BITS + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PAYLOAD_BITS - 1);

    uart_rx_state_t          state;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic [PAYLOAD_BITS-1:0] data_q;
    logic                    valid_pend;
    logic                    valid_q;
    logic                    ferr_q;
    logic                    brk_q;
    logic                    rxd_s;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clock  (clock),
        .resetn (resetn),
        .d      (rx.uart_rxd),
        .q      (rxd_s)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            data_q     <= '0;
            valid_pend <= 1'b0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            // Good frames publish data first and raise valid one cycle later.
            valid_q    <= valid_pend;
            valid_pend <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rxd_s && rx.uart_rx_en) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rxd_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rxd_s, shreg[PAYLOAD_BITS-1:1]};
                        idx   <= idx + 1'b1;
                        if (idx == IDX_LAST) state <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            data_q     <= shreg;
                            valid_pend <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            ferr_q <= 1'b1;
                            brk_q  <= (shreg == '0);
                            state  <= ST_RECOVER;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RECOVER: begin
                    // Any low sample restarts the full-bit idle requirement.
                    if (!rxd_s) begin
                        cnt <= '0;
                    end else if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rx.uart_rx_valid     = valid_q;
    assign rx.uart_rx_data      = data_q;
    assign rx.uart_rx_frame_err = ferr_q;
    assign rx.uart_rx_break     = brk_q;
    assign rx.uart_rx_busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and random frames scored against a frame-level outcome model.
// Bit rate scaled so one bit is 125 clocks, keeping the run short.
module tb_uart_rx;
    localparam int CLK_HZ   = 12_000_000;
    localparam int BIT_RATE = 96_000;
    localparam int PB       = 8;
    localparam int CPB      = CLK_HZ / BIT_RATE;
    localparam int HALF     = CPB / 2;
    localparam int EXP_LAT  = HALF + (PB + 1) * CPB + 1;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    uart_rx_if #(.PAYLOAD_BITS(PB)) rx_bus ();

    uart_rx #(
        .CLK_HZ       (CLK_HZ),
        .BIT_RATE     (BIT_RATE),
        .PAYLOAD_BITS (PB)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .rx     (rx_bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Observed activity
    int            nv = 0, nf = 0, nb = 0, viol = 0;
    int            cyc = 0, start_cyc = 0, last_lat = 0;
    logic [PB-1:0] got_q[$];

    // Expected activity
    int            exp_nv = 0, exp_nf = 0, exp_nb = 0;
    logic [PB-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin : monitor
        logic pv, pf, pb, pbusy;
        pv = 0; pf = 0; pb = 0; pbusy = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (rx_bus.uart_rx_busy && !pbusy) start_cyc = cyc;
            if (rx_bus.uart_rx_valid) begin
                nv++;
                got_q.push_back(rx_bus.uart_rx_data);
                last_lat = cyc - start_cyc;
            end
            if (rx_bus.uart_rx_frame_err) nf++;
            if (rx_bus.uart_rx_break) nb++;
            if (rx_bus.uart_rx_valid && pv) viol++;
            if (rx_bus.uart_rx_frame_err && pf) viol++;
            if (rx_bus.uart_rx_break && pb) viol++;
            if (rx_bus.uart_rx_valid && rx_bus.uart_rx_frame_err) viol++;
            pv    = rx_bus.uart_rx_valid;
            pf    = rx_bus.uart_rx_frame_err;
            pb    = rx_bus.uart_rx_break;
            pbusy = rx_bus.uart_rx_busy;
        end
    end

    initial begin : watchdog
        #(10 * 200_000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx_bus.uart_rxd = v;
        cycles(CPB);
    endtask

    task automatic idle(input int n);
        rx_bus.uart_rxd = 1'b1;
        cycles(n);
    endtask

    task automatic send_frame(input logic [PB-1:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < PB; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
        rx_bus.uart_rxd = 1'b1;
    endtask

    // Frame-level model: what a complete frame must produce.
    task automatic expect_frame(input logic [PB-1:0] d, input logic stop_bit, input logic en);
        if (en) begin
            if (stop_bit) begin
                exp_nv++;
                exp_q.push_back(d);
            end else begin
                exp_nf++;
                if (d == '0) exp_nb++;
            end
        end
    endtask

    task automatic score(input string tag);
        check({tag, "_nvalid"}, nv, exp_nv);
        check({tag, "_nferr"},  nf, exp_nf);
        check({tag, "_nbrk"},   nb, exp_nb);
        while (exp_q.size() > 0) begin
            logic [PB-1:0] e, g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : ~e;
            check({tag, "_data"}, g, e);
        end
        got_q.delete();
    endtask

    initial begin : stim
        logic [PB-1:0] d;
        logic          sb, en;
        rx_bus.uart_rxd   = 1'b1;
        rx_bus.uart_rx_en = 1'b1;
        resetn = 1'b0;
        cycles(5);
        check("rst_valid", rx_bus.uart_rx_valid, 0);
        check("rst_data",  rx_bus.uart_rx_data, 0);
        check("rst_ferr",  rx_bus.uart_rx_frame_err, 0);
        check("rst_brk",   rx_bus.uart_rx_break, 0);
        check("rst_busy",  rx_bus.uart_rx_busy, 0);
        resetn = 1'b1;
        idle(20);

        send_frame(8'hA5, 1'b1); expect_frame(8'hA5, 1'b1, 1'b1);
        idle(10);
        score("a5");
        check("a5_latency", last_lat, EXP_LAT);
        check("a5_idle_busy", rx_bus.uart_rx_busy, 0);

        rx_bus.uart_rxd = 1'b0;
        cycles(CPB * 300 / 1250);
        idle(2 * CPB);
        score("glitch");
        check("glitch_busy", rx_bus.uart_rx_busy, 0);

        send_frame(8'h5A, 1'b1); expect_frame(8'h5A, 1'b1, 1'b1);
        idle(10);
        send_frame(8'h3C, 1'b0); expect_frame(8'h3C, 1'b0, 1'b1);
        idle(2 * CPB);
        score("badstop");
        check("badstop_data_kept", rx_bus.uart_rx_data, 8'h5A);

        rx_bus.uart_rxd = 1'b0;
        cycles(15 * CPB);
        check("break_recover_busy", rx_bus.uart_rx_busy, 1);
        cycles(5 * CPB);
        expect_frame(8'h00, 1'b0, 1'b1);
        idle(2 * CPB);
        check("break_idle_busy", rx_bus.uart_rx_busy, 0);
        send_frame(8'h5A, 1'b1); expect_frame(8'h5A, 1'b1, 1'b1);
        idle(10);
        score("break");

        send_frame(8'h00, 1'b1); expect_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1); expect_frame(8'hFF, 1'b1, 1'b1);
        idle(10);
        score("b2b");

        // Enable dropped mid-frame: the frame in flight still completes.
        fork
            send_frame(8'h3C, 1'b1);
            begin cycles(3 * CPB); rx_bus.uart_rx_en = 1'b0; end
        join
        expect_frame(8'h3C, 1'b1, 1'b1);
        idle(10);
        score("en_midframe");
        rx_bus.uart_rx_en = 1'b1;

        d = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx_bus.uart_rxd = d[4];
        cycles(CPB / 2);
        resetn = 1'b0;
        rx_bus.uart_rxd = 1'b1;
        cycles(3);
        check("midrst_busy", rx_bus.uart_rx_busy, 0);
        check("midrst_data", rx_bus.uart_rx_data, 0);
        resetn = 1'b1;
        idle(2 * CPB);
        score("midrst");
        send_frame(8'h81, 1'b1); expect_frame(8'h81, 1'b1, 1'b1);
        idle(10);
        score("after_rst");

        rx_bus.uart_rx_en = 1'b0;
        send_frame(8'h81, 1'b1); expect_frame(8'h81, 1'b1, 1'b0);
        idle(10);
        score("disabled");
        check("disabled_busy", rx_bus.uart_rx_busy, 0);
        rx_bus.uart_rx_en = 1'b1;

        for (int k = 0; k < 10; k++) begin
            d  = PB'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 4) != 0);
            rx_bus.uart_rx_en = en;
            send_frame(d, sb);
            expect_frame(d, sb, en);
            idle(sb ? $urandom_range(0, 20) : 2 * CPB);
            score($sformatf("rnd%0d", k));
            if (sb && en) check($sformatf("rnd%0d_latency", k), last_lat, EXP_LAT);
        end

        idle(10);
        check("pulse_protocol", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
